// File: rtl/sync_regfile.sv
// sync_regfile: 1-write/1-read register file with a registered read port, a valid strobe,
// and a self-clearing sweep. Define SYNC_REGFILE_BYPASS_EN for write-first same-address reads.
module sync_regfile #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   input  logic              re,
   input  logic [ADDR_W-1:0] ra,
   output logic [DATA_W-1:0] rq,
   output logic              rvalid,
   output logic              busy
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST = '1;

   typedef enum logic {CLEAR, READY} state_t;

   state_t state, state_next;
   logic [ADDR_W-1:0] cnt, cnt_next;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              clearing;
   logic              accept_wr;
   logic              accept_rd;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_wa;
   logic [DATA_W-1:0] mem_wd;
   logic [DATA_W-1:0] rd_data;

   assign clearing  = (state == CLEAR);
   assign accept_wr = !clearing && we && !clr;
   assign accept_rd = !clearing && re && !clr;
   assign busy      = clearing;

   // The sweep shares the single write port; user writes only land outside the sweep.
   assign mem_we = clearing || accept_wr;
   assign mem_wa = clearing ? cnt : wa;
   assign mem_wd = clearing ? '0 : wd;

`ifdef SYNC_REGFILE_BYPASS_EN
   assign rd_data = (we && (wa == ra)) ? wd : mem[ra];
`else
   assign rd_data = mem[ra];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         CLEAR: begin
            if (clr) begin
               cnt_next = '0;
            end else if (cnt == LAST) begin
               state_next = READY;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + ADDR_W'(1);
            end
         end
         READY: begin
            if (clr) begin
               state_next = CLEAR;
               cnt_next   = '0;
            end
         end
         default: begin
            state_next = CLEAR;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_wa] <= mem_wd;
      end
   end

   // rq only moves on an accepted read, so it holds its value between reads and during a sweep.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rq     <= '0;
         rvalid <= 1'b0;
      end else begin
         rvalid <= accept_rd;
         if (accept_rd) begin
            rq <= rd_data;
         end
      end
   end

endmodule

// File: tb/tb_sync_regfile.sv
// tb_sync_regfile: directed self-checking bench for sync_regfile at DATA_W=8, ADDR_W=3.
// Expected read-during-write value follows SYNC_REGFILE_BYPASS_EN.
module tb_sync_regfile;

   logic       clk;
   logic       rst;
   logic       clr;
   logic       we;
   logic [2:0] wa;
   logic [7:0] wd;
   logic       re;
   logic [2:0] ra;
   logic [7:0] rq;
   logic       rvalid;
   logic       busy;

   int checks = 0;
   int errors = 0;

   sync_regfile #(.DATA_W(8), .ADDR_W(3)) dut (
      .clk(clk),
      .rst(rst),
      .clr(clr),
      .we(we),
      .wa(wa),
      .wd(wd),
      .re(re),
      .ra(ra),
      .rq(rq),
      .rvalid(rvalid),
      .busy(busy)
   );

   // 10-time-unit clock; inputs change and outputs are sampled 1 unit after each rising edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic w_en, input logic [2:0] w_addr,
                                input logic [7:0] w_data, input logic r_en,
                                input logic [2:0] r_addr, input logic c);
      we  = w_en;
      wa  = w_addr;
      wd  = w_data;
      re  = r_en;
      ra  = r_addr;
      clr = c;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] exp_rdw;
`ifdef SYNC_REGFILE_BYPASS_EN
      exp_rdw = 8'h3C;
`else
      exp_rdw = 8'h11;
`endif
      rst = 1'b1; clr = 1'b0; we = 1'b0; wa = '0; wd = '0; re = 1'b0; ra = '0;
      @(posedge clk);
      #1;
      checkOutput("reset_rq", rq, 8'h00);
      checkOutput("reset_rvalid", rvalid, 1'b0);
      checkOutput("reset_busy", busy, 1'b1);
      rst = 1'b0;

      // Initial sweep: busy for exactly 8 edges.
      for (int k = 0; k < 8; k++) begin
         checkOutput($sformatf("init_busy_%0d", k), busy, 1'b1);
         applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0);
      end
      checkOutput("init_busy_done", busy, 1'b0);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 1'b0);
         checkOutput($sformatf("init_rvalid_%0d", i), rvalid, 1'b1);
         checkOutput($sformatf("init_rq_%0d", i), rq, 8'h00);
         applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0);
         checkOutput($sformatf("init_idle_rvalid_%0d", i), rvalid, 1'b0);
      end

      // Write then read back, rq holds afterwards.
      applyStimulus(1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 1'b0);
      checkOutput("wr3_no_rvalid", rvalid, 1'b0);
      applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b0);
      checkOutput("rd3_rq", rq, 8'hA5);
      checkOutput("rd3_rvalid", rvalid, 1'b1);
      applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0);
      checkOutput("rd3_hold_rq", rq, 8'hA5);
      checkOutput("rd3_hold_rvalid", rvalid, 1'b0);

      // Same-cycle write and read of one address.
      applyStimulus(1'b1, 3'd5, 8'h11, 1'b0, 3'd0, 1'b0);
      applyStimulus(1'b1, 3'd5, 8'h3C, 1'b1, 3'd5, 1'b0);
      checkOutput("rdw5_rq", rq, 32'(exp_rdw));
      checkOutput("rdw5_rvalid", rvalid, 1'b1);
      applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 1'b0);
      checkOutput("rdw5_after_rq", rq, 8'h3C);

      // Streaming reads of i*0x11.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 3'(i), 8'(i * 8'h11), 1'b0, 3'd0, 1'b0);
      end
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 1'b0);
         checkOutput($sformatf("stream_rvalid_%0d", i), rvalid, 1'b1);
         checkOutput($sformatf("stream_rq_%0d", i), rq, 8'(i * 8'h11));
      end
      applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0);
      checkOutput("stream_end_rvalid", rvalid, 1'b0);
      checkOutput("stream_end_rq", rq, 8'h77);

      // Fill with 0xFF, then a clr pulse that also carries a read and a write.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 3'(i), 8'hFF, 1'b0, 3'd0, 1'b0);
      end
      applyStimulus(1'b1, 3'd0, 8'hAB, 1'b1, 3'd0, 1'b1);
      checkOutput("clr_rvalid", rvalid, 1'b0);
      checkOutput("clr_rq_hold", rq, 8'h77);
      // Writes aimed at entries the sweep has already cleared must not land.
      for (int k = 0; k < 8; k++) begin
         checkOutput($sformatf("clr_busy_%0d", k), busy, 1'b1);
         applyStimulus(1'b1, 3'(k + 7), 8'hEE, 1'b1, 3'd2, 1'b0);
         checkOutput($sformatf("clr_busy_rvalid_%0d", k), rvalid, 1'b0);
         checkOutput($sformatf("clr_busy_rq_%0d", k), rq, 8'h77);
      end
      checkOutput("clr_busy_done", busy, 1'b0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 1'b0);
         checkOutput($sformatf("clr_rd_rq_%0d", i), rq, 8'h00);
         checkOutput($sformatf("clr_rd_rvalid_%0d", i), rvalid, 1'b1);
      end

      // Reset in the middle of a sweep with a read pending.
      applyStimulus(1'b1, 3'd1, 8'h5A, 1'b0, 3'd0, 1'b0);
      applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 1'b0);
      checkOutput("pre_rst_rq", rq, 8'h5A);
      applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0);
      end
      checkOutput("mid_sweep_busy", busy, 1'b1);
      re = 1'b1;
      ra = 3'd1;
      #2;
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_rq", rq, 8'h00);
      checkOutput("mid_rst_rvalid", rvalid, 1'b0);
      checkOutput("mid_rst_busy", busy, 1'b1);
      @(posedge clk);
      #1;
      re  = 1'b0;
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         checkOutput($sformatf("rst_busy_%0d", k), busy, 1'b1);
         applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0);
      end
      checkOutput("rst_busy_done", busy, 1'b0);
      applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 1'b0);
      checkOutput("rst_rd1_rq", rq, 8'h00);
      checkOutput("rst_rd1_rvalid", rvalid, 1'b1);
      applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
